// File: rtl/var_bw_mul_pkg.sv
// Shared types for the variable bit-width multiplier sequencer: op modes,
// issue kinds, the result-FIFO entry layout and a saturating-increment helper.
package var_bw_mul_pkg;

    localparam logic MODE_16 = 1'b0;
    localparam logic MODE_8  = 1'b1;

    // Widest tag the result entry can carry; the top uses the low TAG_W bits.
    localparam int TAG_W_MAX = 16;

    typedef enum logic [1:0] {
        ISS_16,
        ISS_PAIR,
        ISS_LONE
    } iss_kind_e;

    typedef struct packed {
        logic [31:0]          p;
        logic                 mode;
        logic [TAG_W_MAX-1:0] tag;
    } res_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/var_bw_mul_res_fifo.sv
// Two-entry result FIFO. Entry 0 is the head and drives the consumer directly,
// so the head is a registered output; push2 writes two entries, d0 first.
module var_bw_mul_res_fifo
    import var_bw_mul_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push1,
    input  logic       push2,
    input  res_entry_t push_d0,
    input  res_entry_t push_d1,
    input  logic       pop,
    output logic [1:0] free,
    output logic       head_valid,
    output res_entry_t head
);

    res_entry_t e0_q, e0_d;
    res_entry_t e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;

        if (pop && cnt_q != 2'd0) begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
        end

        // The caller only pushes what fits in the entries free at cycle start.
        if (push2) begin
            if (cnt_d == 2'd0) begin
                e0_d  = push_d0;
                e1_d  = push_d1;
                cnt_d = 2'd2;
            end
        end else if (push1) begin
            if (cnt_d == 2'd0) begin
                e0_d = push_d0;
            end else begin
                e1_d = push_d0;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    // NOTE: the entries are reset too, not just the count, because entry 0 is
    // the visible out_* register and must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign free       = 2'd2 - cnt_q;
    assign head_valid = (cnt_q != 2'd0);
    assign head       = e0_q;

endmodule

// File: rtl/var_bw_mul_sched.sv
// Sequencer in front of the 16x16 / dual 8x8 multiplier: pairs 8-bit ops,
// issues 16-bit ops singly, returns results in order. Optional: VAR_BW_MUL_SCHED_STATS_EN.
module var_bw_mul_sched
    import var_bw_mul_pkg::*;
#(
    parameter int TAG_W        = 4,
    parameter int PAIR_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_para_mode,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    input  logic [31:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_p,
    output logic             out_mode,
    output logic [TAG_W-1:0] out_tag
`ifdef VAR_BW_MUL_SCHED_STATS_EN
    ,
    output logic [15:0]      stat_issue16,
    output logic [15:0]      stat_issue_pair,
    output logic [15:0]      stat_issue_lone,
    output logic [15:0]      stat_results
`endif
);

    localparam logic [3:0] TIMEOUT_C = 4'(PAIR_TIMEOUT);

    // Pending slot: one 8-bit op waiting for a partner.
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       pend_a_q, pend_a_d;
    logic [7:0]       pend_b_q, pend_b_d;
    logic [TAG_W-1:0] pend_tag_q, pend_tag_d;
    logic [3:0]       cnt_q, cnt_d;

    // Issue register: tag0 is the only/older op, tag1 the younger of a pair.
    logic             iss_valid_q, iss_valid_d;
    iss_kind_e        iss_kind_q, iss_kind_d;
    logic             iss_para_q, iss_para_d;
    logic [15:0]      iss_a_q, iss_a_d;
    logic [15:0]      iss_b_q, iss_b_d;
    logic [TAG_W-1:0] iss_tag0_q, iss_tag0_d;
    logic [TAG_W-1:0] iss_tag1_q, iss_tag1_d;

    logic       fifo_push1, fifo_push2, fifo_pop, fifo_head_valid;
    logic [1:0] fifo_free;
    res_entry_t res_d0, res_d1, fifo_head;

    logic retire, slot_ok, acc, acc16, acc8, load_pend, pair, flush;
    logic unused_head_tag;

    assign retire    = iss_valid_q &&
                       (fifo_free >= ((iss_kind_q == ISS_PAIR) ? 2'd2 : 2'd1));
    assign slot_ok   = !iss_valid_q || retire;
    assign in_ready  = !rst && slot_ok && !(pend_valid_q && in_mode == MODE_16);
    assign acc       = in_valid && in_ready;
    assign acc16     = acc && (in_mode == MODE_16);
    assign acc8      = acc && (in_mode == MODE_8);
    assign load_pend = acc8 && !pend_valid_q;
    assign pair      = acc8 && pend_valid_q;
    // A waiting 16-bit op forces the lone flush so it can never overtake PEND.
    assign flush     = pend_valid_q && slot_ok && !acc8 &&
                       ((in_valid && in_mode == MODE_16) || cnt_q == TIMEOUT_C);

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_a_d     = pend_a_q;
        pend_b_d     = pend_b_q;
        pend_tag_d   = pend_tag_q;
        cnt_d        = cnt_q;

        if (pair || flush) begin
            pend_valid_d = 1'b0;
            cnt_d        = 4'd0;
        end else if (load_pend) begin
            pend_valid_d = 1'b1;
            pend_a_d     = in_a[7:0];
            pend_b_d     = in_b[7:0];
            pend_tag_d   = in_tag;
            cnt_d        = 4'd0;
        end else if (pend_valid_q && cnt_q != TIMEOUT_C) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_comb begin
        iss_valid_d = iss_valid_q && !retire;
        iss_kind_d  = iss_kind_q;
        iss_para_d  = iss_para_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_tag0_d  = iss_tag0_q;
        iss_tag1_d  = iss_tag1_q;

        if (acc16) begin
            iss_valid_d = 1'b1;
            iss_kind_d  = ISS_16;
            iss_para_d  = 1'b0;
            iss_a_d     = in_a;
            iss_b_d     = in_b;
            iss_tag0_d  = in_tag;
        end else if (pair) begin
            iss_valid_d = 1'b1;
            iss_kind_d  = ISS_PAIR;
            iss_para_d  = 1'b1;
            iss_a_d     = {in_a[7:0], pend_a_q};
            iss_b_d     = {in_b[7:0], pend_b_q};
            iss_tag0_d  = pend_tag_q;
            iss_tag1_d  = in_tag;
        end else if (flush) begin
            iss_valid_d = 1'b1;
            iss_kind_d  = ISS_LONE;
            iss_para_d  = 1'b1;
            iss_a_d     = {8'h00, pend_a_q};
            iss_b_d     = {8'h00, pend_b_q};
            iss_tag0_d  = pend_tag_q;
        end
    end

    always_comb begin
        res_d0      = '0;
        res_d1      = '0;
        res_d0.tag[TAG_W-1:0] = iss_tag0_q;
        res_d1.tag[TAG_W-1:0] = iss_tag1_q;
        res_d1.p    = {16'h0000, mul_p[31:16]};
        res_d1.mode = MODE_8;
        if (iss_kind_q == ISS_16) begin
            res_d0.p    = mul_p;
            res_d0.mode = MODE_16;
        end else begin
            res_d0.p    = {16'h0000, mul_p[15:0]};
            res_d0.mode = MODE_8;
        end
    end

    assign fifo_push1 = retire && (iss_kind_q != ISS_PAIR);
    assign fifo_push2 = retire && (iss_kind_q == ISS_PAIR);
    assign fifo_pop   = fifo_head_valid && out_ready;

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_a_q     <= 8'h00;
            pend_b_q     <= 8'h00;
            pend_tag_q   <= '0;
            cnt_q        <= 4'd0;
            iss_valid_q  <= 1'b0;
            iss_kind_q   <= ISS_16;
            iss_para_q   <= 1'b0;
            iss_a_q      <= 16'h0000;
            iss_b_q      <= 16'h0000;
            iss_tag0_q   <= '0;
            iss_tag1_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            pend_tag_q   <= pend_tag_d;
            cnt_q        <= cnt_d;
            iss_valid_q  <= iss_valid_d;
            iss_kind_q   <= iss_kind_d;
            iss_para_q   <= iss_para_d;
            iss_a_q      <= iss_a_d;
            iss_b_q      <= iss_b_d;
            iss_tag0_q   <= iss_tag0_d;
            iss_tag1_q   <= iss_tag1_d;
        end
    end

    var_bw_mul_res_fifo u_res_fifo (
        .clk        (clk),
        .rst        (rst),
        .push1      (fifo_push1),
        .push2      (fifo_push2),
        .push_d0    (res_d0),
        .push_d1    (res_d1),
        .pop        (fifo_pop),
        .free       (fifo_free),
        .head_valid (fifo_head_valid),
        .head       (fifo_head)
    );

    assign mul_para_mode   = iss_para_q;
    assign mul_a           = iss_a_q;
    assign mul_b           = iss_b_q;
    assign out_valid       = fifo_head_valid;
    assign out_p           = fifo_head.p;
    assign out_mode        = fifo_head.mode;
    assign out_tag         = fifo_head.tag[TAG_W-1:0];
    assign unused_head_tag = ^fifo_head.tag;

`ifdef VAR_BW_MUL_SCHED_STATS_EN
    logic [15:0] st_issue16_q, st_issue16_d;
    logic [15:0] st_pair_q, st_pair_d;
    logic [15:0] st_lone_q, st_lone_d;
    logic [15:0] st_results_q, st_results_d;

    always_comb begin
        st_issue16_d = sat_inc16(st_issue16_q, acc16);
        st_pair_d    = sat_inc16(st_pair_q, pair);
        st_lone_d    = sat_inc16(st_lone_q, flush);
        st_results_d = sat_inc16(st_results_q, fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_issue16_q <= 16'h0000;
            st_pair_q    <= 16'h0000;
            st_lone_q    <= 16'h0000;
            st_results_q <= 16'h0000;
        end else begin
            st_issue16_q <= st_issue16_d;
            st_pair_q    <= st_pair_d;
            st_lone_q    <= st_lone_d;
            st_results_q <= st_results_d;
        end
    end

    assign stat_issue16    = st_issue16_q;
    assign stat_issue_pair = st_pair_q;
    assign stat_issue_lone = st_lone_q;
    assign stat_results    = st_results_q;
`endif

endmodule
